// File: rtl/bus_driver_lectura_if.sv
// bus_driver_lectura_if: load address, peripheral read ports and registered return data
interface bus_driver_lectura_if #(parameter int DATA_W = 32);
    logic [DATA_W-1:0] address_i;
    logic [DATA_W-1:0] out_ram_i;
    logic [DATA_W-1:0] out_teclado_i;
    logic [DATA_W-1:0] out_switch_i;
    logic [DATA_W-1:0] out_uart_i;
    logic [DATA_W-1:0] out_timer_i;
    logic [DATA_W-1:0] out_spi_i;
    logic [DATA_W-1:0] d_o;
    logic              addr_err_o;
    modport master (
        output address_i, out_ram_i, out_teclado_i, out_switch_i,
        output out_uart_i, out_timer_i, out_spi_i,
        input  d_o, addr_err_o
    );
    modport slave (
        input  address_i, out_ram_i, out_teclado_i, out_switch_i,
        input  out_uart_i, out_timer_i, out_spi_i,
        output d_o, addr_err_o
    );
endinterface

// File: rtl/bus_driver_lectura.sv
// bus_driver_lectura: decodes the load address and registers the selected peripheral word
module bus_driver_lectura #(
    parameter int DATA_W = 32
) (
    input logic                 clk_i,
    input logic                 rst_i,
    bus_driver_lectura_if.slave bus
);
    logic              sel_ram, sel_kbd, sel_sw, sel_tmr, sel_uart, sel_spi, unmapped;
    logic [DATA_W-1:0] mux;
    logic              unused_low;

    assign unused_low = ^bus.address_i[1:0];

    // Word-granular decode; the regions are disjoint so priority order is irrelevant.
    always_comb begin
        sel_ram  = bus.address_i[31:12] == 20'h00001;
        sel_kbd  = bus.address_i[31:2] == 30'(32'h2000 >> 2);
        sel_sw   = bus.address_i[31:2] == 30'(32'h2004 >> 2);
        sel_tmr  = bus.address_i[31:4] == 28'h0000201;
        sel_uart = bus.address_i[31:4] == 28'h0000202;
        sel_spi  = bus.address_i[31:9] == 23'h11;
        unmapped = !(sel_ram || sel_kbd || sel_sw || sel_tmr || sel_uart || sel_spi);
        mux = sel_ram  ? bus.out_ram_i     :
              sel_kbd  ? bus.out_teclado_i :
              sel_sw   ? bus.out_switch_i  :
              sel_tmr  ? bus.out_timer_i   :
              sel_uart ? bus.out_uart_i    :
              sel_spi  ? bus.out_spi_i     : '0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bus.d_o        <= '0;
            bus.addr_err_o <= 1'b0;
        end else begin
            bus.d_o        <= mux;
            bus.addr_err_o <= unmapped;
        end
    end
endmodule

// File: tb/tb_bus_driver_lectura.sv
// tb_bus_driver_lectura: vector table, corner sequences and random run against an address-range model
module tb_bus_driver_lectura;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;

    bus_driver_lectura_if #(.DATA_W(32)) bus ();
    bus_driver_lectura #(.DATA_W(32)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] exp_d;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic set_srcs(input logic [31:0] r, k, s, u, t, p);
        bus.out_ram_i = r;
        bus.out_teclado_i = k;
        bus.out_switch_i = s;
        bus.out_uart_i = u;
        bus.out_timer_i = t;
        bus.out_spi_i = p;
    endtask

    function automatic logic [32:0] model(input logic [31:0] addr, input logic [31:0] r, k, s, u, t, p);
        logic [31:0] a;
        a = addr & 32'hFFFF_FFFC;
        if (a >= 32'h1000 && a <= 32'h1FFF) return {1'b0, r};
        if (a == 32'h2000) return {1'b0, k};
        if (a == 32'h2004) return {1'b0, s};
        if (a >= 32'h2010 && a <= 32'h201F) return {1'b0, t};
        if (a >= 32'h2020 && a <= 32'h202F) return {1'b0, u};
        if (a >= 32'h2200 && a <= 32'h23FF) return {1'b0, p};
        return {1'b1, 32'h0};
    endfunction

    task automatic step_check(input string name, input logic [31:0] exp_d, input logic exp_err);
        @(posedge clk);
        #1;
        chk({name, "_d"}, bus.d_o, exp_d);
        chk({name, "_err"}, {31'h0, bus.addr_err_o}, {31'h0, exp_err});
    endtask

    initial begin
        logic [31:0] r, k, s, u, t, p, a;
        logic [32:0] m;
        vecs = '{
            '{32'h1004, 32'h385, 1'b0}, '{32'h2000, 32'h4A, 1'b0}, '{32'h2004, 32'h39, 1'b0},
            '{32'h2024, 32'h55, 1'b0},  '{32'h2010, 32'h4, 1'b0},  '{32'h2200, 32'hFF, 1'b0},
            '{32'h1000, 32'h385, 1'b0}, '{32'h1FFC, 32'h385, 1'b0}, '{32'h201C, 32'h4, 1'b0},
            '{32'h2020, 32'h55, 1'b0},  '{32'h202C, 32'h55, 1'b0},  '{32'h23FC, 32'hFF, 1'b0},
            '{32'h0FFC, 32'h0, 1'b1},   '{32'h2400, 32'h0, 1'b1},   '{32'h0, 32'h0, 1'b1},
            '{32'h2008, 32'h0, 1'b1},   '{32'h2030, 32'h0, 1'b1},   '{32'hFFFFFFFC, 32'h0, 1'b1},
            '{32'h1000, 32'h385, 1'b0}, '{32'h200C, 32'h0, 1'b1},   '{32'h2027, 32'h55, 1'b0}
        };
        set_srcs(32'h385, 32'h4A, 32'h39, 32'h55, 32'h4, 32'hFF);
        bus.address_i = 32'h1004;
        #1;
        chk("por_d", bus.d_o, 32'h0);
        #20;
        @(negedge clk);
        rst = 1'b0;
        step_check("first_load", 32'h385, 1'b0);
        // Asynchronous reset between edges must clear immediately and hold across an edge.
        #2 rst = 1'b1;
        #1;
        chk("rst_async_d", bus.d_o, 32'h0);
        chk("rst_async_err", {31'h0, bus.addr_err_o}, 32'h0);
        step_check("rst_hold", 32'h0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_release_d", bus.d_o, 32'h0);
        step_check("post_rst", 32'h385, 1'b0);

        foreach (vecs[i]) begin
            @(negedge clk);
            bus.address_i = vecs[i].addr;
            step_check($sformatf("vec%0d_%08h", i, vecs[i].addr), vecs[i].exp_d, vecs[i].exp_err);
        end

        @(negedge clk);
        bus.address_i = 32'h2000;
        step_check("kbd_hold", 32'h4A, 1'b0);
        @(negedge clk);
        bus.out_teclado_i = 32'h7E;
        #1;
        chk("kbd_before_edge", bus.d_o, 32'h4A);
        step_check("kbd_live", 32'h7E, 1'b0);

        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            r = $urandom; k = $urandom; s = $urandom; u = $urandom; t = $urandom; p = $urandom;
            a = ($urandom_range(0, 7) == 0) ? 32'($urandom) : 32'($urandom_range(32'h0F00, 32'h2500));
            set_srcs(r, k, s, u, t, p);
            bus.address_i = a;
            m = model(a, r, k, s, u, t, p);
            step_check($sformatf("rand_%08h", a), m[31:0], m[32]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/bus_driver_lectura.md
Name: bus_driver_lectura

Overview:
Read-data return multiplexer for the RISC-V processor's data bus. It decodes the CPU load address and selects one 32-bit source: RAM, keyboard, switches, UART, timer or SPI. The selected word is registered and returned to the core on d_o. It sits between the peripheral read ports and the processor's load-data input, in parallel with the write-side bus driver.

Parameters:
DATA_W, 32, width of address and all data paths; only 32 is supported.

Ports:
clk_i  input  1  system clock; all state updates on rising edge.
rst_i  input  1  asynchronous reset, active-high.
address_i  input  32  byte address of the current load.
out_ram_i  input  32  read data from data RAM.
out_teclado_i  input  32  read data from keyboard controller.
out_switch_i  input  32  read data from switch register.
out_uart_i  input  32  read data from UART register block.
out_timer_i  input  32  read data from timer register block.
out_spi_i  input  32  read data from SPI controller/buffer.
d_o  output  32  registered selected read data.
addr_err_o  output  1  registered flag; 1 when the address hit no mapped region.

Behaviour:
- Decode is combinational on address_i. address_i[1:0] is ignored, so accesses are word-granular.
- RAM: address_i[31:12] == 20'h00001, range 0x1000–0x1FFF.
- Keyboard: address_i[31:2] == 0x2000>>2, address 0x2000 only.
- Switches: address_i[31:2] == 0x2004>>2, address 0x2004 only.
- Timer: address_i[31:4] == 28'h0000201, range 0x2010–0x201F.
- UART: address_i[31:4] == 28'h0000202, range 0x2020–0x202F.
- SPI: address_i[31:9] == 23'h11, range 0x2200–0x23FF.
- The regions are disjoint; exactly one or zero selects are active at any time.
- Any other address is unmapped: the mux value is 32'h0 and the error value is 1.
- On each rising edge of clk_i: d_o <= mux value; addr_err_o <= unmapped.
- Latency: exactly 1 cycle from a stable address_i to d_o and addr_err_o.
- Source data is sampled at that same clock edge. A source changing while the address is held is reflected on the next edge.
- Reset: rst_i high forces d_o = 32'h0 and addr_err_o = 0 immediately, independent of clk_i. Both hold while rst_i is high.
- After rst_i deasserts, the first rising edge loads normally. Reset asserted mid-access discards that access; there is no pending state to recover.
- There are no other state elements: no FSM, no enables, no handshake. A new read is performed every cycle.
- Region boundaries are inclusive as listed.
  - 0x0FFC and 0x2400 are unmapped.
  - 0x2008, 0x200C, 0x2030–0x21FF and 0x0–0x0FFF are unmapped.

Test Plan:
- Reset: with sources RAM=0x385, KBD=0x4A, SW=0x39, UART=0x55, TMR=0x4, SPI=0xFF and address 0x1004, assert rst_i between edges -> d_o=0 and addr_err_o=0 immediately; they stay 0 until the first edge after release, then d_o=0x385.
- Per-source select, with the same source values and one address per cycle:
  - 0x1004 -> 0x385; 0x2000 -> 0x4A; 0x2004 -> 0x39.
  - 0x2024 -> 0x55; 0x2010 -> 0x4; 0x2200 -> 0xFF.
  - Each appears one edge after the address is applied; addr_err_o=0.
- Boundaries:
  - 0x1000 and 0x1FFC -> 0x385.
  - 0x201C -> 0x4; 0x2020 and 0x202C -> 0x55.
  - 0x23FC -> 0xFF.
  - 0x0FFC and 0x2400 -> 0 with addr_err_o=1.
- Unmapped holes: 0x0, 0x2008, 0x2030 and 0xFFFFFFFC -> d_o=0, addr_err_o=1. The next mapped address clears addr_err_o on the following edge.
- Low-bit ignore and live data: 0x2027 -> UART data. Hold 0x2000 and change KBD from 0x4A to 0x7E -> d_o=0x7E one edge later.
